router_flit_tx: RTL and testbench

ROUTER_FLIT_TX -- requirements
Module: router_flit_tx

---
 rtl/router_pkg.sv | 32 +++
 rtl/router_credit_cnt.sv | 43 ++++
 rtl/router_flit_tx.sv | 127 ++++++++++++
 tb/tb_router_flit_tx.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared flit-format and transmit-FSM definitions for the router link.
// The receiving router wrapper imports the same package to decode flits.
package router_pkg;

  localparam int TYPE_W = 2;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_TAIL      = 2'b01,
    FT_HEAD      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    BODY = 2'b10
  } tx_state_e;

  // The head payload is {len, dst_y, dst_x}, right-aligned in the flit payload.
  localparam int HEAD_X_LSB = 0;

  function automatic int head_y_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int head_len_lsb(input int coord_w);
    return 2 * coord_w;
  endfunction

endpackage

// File: rtl/router_credit_cnt.sv
// Downstream buffer credit tracker: saturates at CREDITS and records overflow.
// avail depends only on the stored count, so returned credit is usable one cycle later.
module router_credit_cnt #(
  parameter int CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  input  logic give,
  output logic avail,
  output logic ovf
);

  localparam int               CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count;
  logic             inc;
  logic             dec;
  logic             overflow;

  assign dec      = consume && (count != '0);
  assign overflow = give && !dec && (count == FULL);
  assign inc      = give && !overflow;
  assign avail    = (count != '0);

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= FULL;
      ovf   <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (overflow) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/router_flit_tx.sv
// Packet-to-flit transmitter: turns a request plus body words into head/body/tail
// flits, gated by downstream credits (no backpressure on the flit link).
module router_flit_tx
  import router_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dst_x,
  input  logic [COORD_W-1:0] req_dst_y,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               body_valid,
  output logic               body_ready,
  input  logic [FLIT_W-3:0]  body_data,
  output logic               flit_valid,
  output logic [FLIT_W-1:0]  flit_data,
  input  logic               credit_in
);

  localparam int PAY_W   = FLIT_W - TYPE_W;
  localparam int Y_LSB   = head_y_lsb(COORD_W);
  localparam int LEN_LSB = head_len_lsb(COORD_W);

  tx_state_e          state;
  tx_state_e          state_next;
  logic [COORD_W-1:0] dst_x_q;
  logic [COORD_W-1:0] dst_y_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   remaining;
  logic               avail;
  logic               err_credit_ovf;
  logic [PAY_W-1:0]   head_payload;
  flit_type_e         flit_type;
  logic [PAY_W-1:0]   flit_payload;

  router_credit_cnt #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk     (clk),
    .rst_n   (rst_n),
    .consume (flit_valid),
    .give    (credit_in),
    .avail   (avail),
    .ovf     (err_credit_ovf)
  );

  // NOTE: every combinational output gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    head_payload                          = '0;
    head_payload[HEAD_X_LSB +: COORD_W]   = dst_x_q;
    head_payload[Y_LSB +: COORD_W]        = dst_y_q;
    head_payload[LEN_LSB +: LEN_W]        = len_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      len_q     <= '0;
      remaining <= '0;
    end else begin
      state <= state_next;
      if (req_valid && req_ready) begin
        dst_x_q <= req_dst_x;
        dst_y_q <= req_dst_y;
        len_q   <= req_len;
      end
      if (state == HEAD && avail) begin
        remaining <= len_q;
      end else if (state == BODY && body_valid && body_ready) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Head flits come only from latched request fields and the stored credit
  // count; body flits pass body_data straight through in the handshake cycle.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    body_ready   = 1'b0;
    flit_valid   = 1'b0;
    flit_type    = FT_BODY;
    flit_payload = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = HEAD;
      end
      HEAD: begin
        if (avail) begin
          flit_valid   = 1'b1;
          flit_payload = head_payload;
          if (len_q == '0) begin
            flit_type  = FT_HEAD_TAIL;
            state_next = IDLE;
          end else begin
            flit_type  = FT_HEAD;
            state_next = BODY;
          end
        end
      end
      BODY: begin
        body_ready = avail;
        if (body_valid && avail) begin
          flit_valid   = 1'b1;
          flit_payload = body_data;
          if (remaining == LEN_W'(1)) begin
            flit_type  = FT_TAIL;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign flit_data = {flit_type, flit_payload};

endmodule

// File: tb/tb_router_flit_tx.sv
// Scoreboard bench for router_flit_tx: tests push hand-computed flits,
// a negedge monitor pops and compares every flit the DUT presents.
module tb_router_flit_tx;
  import router_pkg::*;

  localparam int COORD_W = 8;
  localparam int FLIT_W  = 32;
  localparam int CREDITS = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [COORD_W-1:0] req_dst_x = '0;
  logic [COORD_W-1:0] req_dst_y = '0;
  logic [3:0]         req_len = '0;
  logic               body_valid;
  logic               body_ready;
  logic [FLIT_W-3:0]  body_data;
  logic               flit_valid;
  logic [FLIT_W-1:0]  flit_data;
  logic               credit_in;

  router_flit_tx #(
    .COORD_W (COORD_W),
    .FLIT_W  (FLIT_W),
    .CREDITS (CREDITS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_dst_x  (req_dst_x),
    .req_dst_y  (req_dst_y),
    .req_len    (req_len),
    .body_valid (body_valid),
    .body_ready (body_ready),
    .body_data  (body_data),
    .flit_valid (flit_valid),
    .flit_data  (flit_data),
    .credit_in  (credit_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: test writes exp_q, monitor advances exp_rd.
  logic [FLIT_W-1:0] exp_q[$];
  int                exp_rd = 0;
  int                flit_cyc[$];
  int                cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n && flit_valid) begin
      flit_cyc.push_back(cyc);
      if (exp_rd < exp_q.size()) begin
        check($sformatf("flit%0d", exp_rd), flit_data, exp_q[exp_rd]);
        exp_rd++;
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got 0x%0h expected no flit", flit_data);
      end
    end
  end

  // Body source: presents body_q words in order, with body_gap idle cycles after each handshake.
  logic [FLIT_W-3:0] body_q[$];
  int                body_rd = 0;
  int                body_gap = 0;

  initial begin
    int gap_left;
    bit hs;
    gap_left   = 0;
    body_valid = 1'b0;
    body_data  = '0;
    forever begin
      @(negedge clk);
      hs = rst_n && body_valid && body_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        body_rd++;
        gap_left = body_gap;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      body_valid = (body_rd < body_q.size()) && (gap_left == 0);
      body_data  = body_valid ? body_q[body_rd] : '0;
    end
  end

  // Credit source: automatic return two cycles after each flit, or manual pulses on request.
  bit   auto_credit = 1'b0;
  int   credit_req = 0;

  initial begin
    int       credit_done;
    bit       sent;
    bit [1:0] cpipe;
    credit_done = 0;
    cpipe       = 2'b00;
    credit_in   = 1'b0;
    forever begin
      @(negedge clk);
      sent = rst_n && flit_valid;
      @(posedge clk);
      #1;
      credit_in = (auto_credit && cpipe[1]) || (credit_req > credit_done);
      if (credit_req > credit_done) credit_done++;
      cpipe = {cpipe[0], sent};
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a request for one cycle; returns at the start of the head cycle.
  task automatic issue_req(input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] len, input bit credit_with_head);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_dst_x = x;
    req_dst_y = y;
    req_len   = len;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    if (credit_with_head) credit_req++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_rd < exp_q.size() && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_rd, exp_q.size());
  endtask

  initial begin
    int base;
    int n0;

    // Reset state
    tick(3);
    check("rst_req_ready",  req_ready, 1'b1);
    check("rst_body_ready", body_ready, 1'b0);
    check("rst_flit_valid", flit_valid, 1'b0);
    check("rst_flit_data",  flit_data, 32'h0);
    check("rst_credits",    dut.u_credit.count, 4);
    check("rst_ovf",        dut.err_credit_ovf, 1'b0);
    rst_n = 1'b1;
    tick(2);

    // Header-only packet to (3,5)
    exp_q.push_back(32'hC000_0503);
    issue_req(8'd3, 8'd5, 4'd0, 1'b0);
    @(negedge clk);
    check("hdr_only_latency", flit_valid, 1'b1);
    tick(2);
    check("hdr_only_credits", dut.u_credit.count, 3);
    check("hdr_only_idle",    req_ready, 1'b1);
    wait_drain("hdr_only", 10);
    credit_req++;
    tick(3);
    check("hdr_only_restore", dut.u_credit.count, 4);

    // len=3, continuous body, credits returned two cycles after each flit
    auto_credit = 1'b1;
    body_q.push_back(30'h0123_4567);
    body_q.push_back(30'h2AAA_5555);
    body_q.push_back(30'h3FFF_FFFF);
    exp_q.push_back(32'h8003_0201);
    exp_q.push_back(32'h0123_4567);
    exp_q.push_back(32'h2AAA_5555);
    exp_q.push_back(32'h7FFF_FFFF);
    issue_req(8'd1, 8'd2, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("len3_consec%0d", i), flit_valid, 1'b1);
    end
    wait_drain("len3", 10);
    tick(6);
    check("len3_credits_end", dut.u_credit.count, 4);
    auto_credit = 1'b0;

    // len=6 with no credit return: stalls after 4 flits
    base = exp_rd;
    for (int i = 0; i < 6; i++) body_q.push_back(30'(32'h100 + i));
    exp_q.push_back(32'h8006_2211);
    for (int i = 0; i < 5; i++) exp_q.push_back(32'h100 + i);
    exp_q.push_back(32'h4000_0105);
    issue_req(8'h11, 8'h22, 4'd6, 1'b0);
    tick(8);
    check("stall_flit_count", exp_rd - base, 4);
    check("stall_body_ready", body_ready, 1'b0);
    check("stall_credits",    dut.u_credit.count, 0);
    credit_req++;
    @(negedge clk);
    check("credit_not_same_cycle", flit_valid, 1'b0);
    @(negedge clk);
    check("credit_next_cycle", flit_valid, 1'b1);
    @(negedge clk);
    check("credit_only_one", flit_valid, 1'b0);
    check("one_more_flit", exp_rd - base, 5);
    credit_req += 6;
    wait_drain("len6", 20);
    tick(4);
    check("len6_credits_end", dut.u_credit.count, 4);
    check("len6_no_ovf",      dut.err_credit_ovf, 1'b0);

    // Send and credit in the same cycle at count 1, then overflow at full
    body_q.push_back(30'h55);
    body_q.push_back(30'h66);
    exp_q.push_back(32'h8002_0000);
    exp_q.push_back(32'h0000_0055);
    exp_q.push_back(32'h4000_0066);
    issue_req(8'd0, 8'd0, 4'd2, 1'b0);
    wait_drain("len2", 10);
    tick(1);
    check("count_at_1", dut.u_credit.count, 1);
    exp_q.push_back(32'hC000_FFFF);
    issue_req(8'hFF, 8'hFF, 4'd0, 1'b1);
    @(negedge clk);
    check("send_with_credit_valid", flit_valid, 1'b1);
    @(negedge clk);
    check("send_with_credit_hold", dut.u_credit.count, 1);
    credit_req += 3;
    tick(5);
    check("refill_full", dut.u_credit.count, 4);
    check("refill_no_ovf", dut.err_credit_ovf, 1'b0);
    credit_req++;
    tick(3);
    check("ovf_saturate", dut.u_credit.count, 4);
    check("ovf_set", dut.err_credit_ovf, 1'b1);

    // Reset in the middle of a len=5 packet after 2 body flits
    body_q.push_back(30'h0BAD);
    body_q.push_back(30'h0BEE);
    exp_q.push_back(32'h8005_0402);
    exp_q.push_back(32'h0000_0BAD);
    exp_q.push_back(32'h0000_0BEE);
    issue_req(8'd2, 8'd4, 4'd5, 1'b0);
    wait_drain("mid_rst", 10);
    tick(2);
    check("mid_rst_body_ready", body_ready, 1'b1);
    check("ovf_sticky", dut.err_credit_ovf, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready",  req_ready, 1'b1);
    check("mid_rst_body_ready0", body_ready, 1'b0);
    check("mid_rst_flit_valid", flit_valid, 1'b0);
    check("mid_rst_flit_data",  flit_data, 32'h0);
    check("mid_rst_credits",    dut.u_credit.count, 4);
    check("mid_rst_ovf",        dut.err_credit_ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    auto_credit = 1'b1;
    body_q.push_back(30'h1234);
    exp_q.push_back(32'h8001_0907);
    exp_q.push_back(32'h4000_1234);
    issue_req(8'd7, 8'd9, 4'd1, 1'b0);
    wait_drain("post_rst", 10);
    tick(6);
    check("post_rst_credits", dut.u_credit.count, 4);

    // len=2 with 3-cycle gaps in body_valid
    body_gap = 3;
    n0 = flit_cyc.size();
    body_q.push_back(30'h3000_0000);
    body_q.push_back(30'h0000_0ABC);
    exp_q.push_back(32'h8002_F00F);
    exp_q.push_back(32'h3000_0000);
    exp_q.push_back(32'h4000_0ABC);
    issue_req(8'h0F, 8'hF0, 4'd2, 1'b0);
    wait_drain("gap", 20);
    tick(6);
    check("gap_flit_count", flit_cyc.size() - n0, 3);
    if (flit_cyc.size() - n0 >= 3) begin
      check("gap_head_to_body", flit_cyc[n0+1] - flit_cyc[n0], 1);
      check("gap_body_to_tail", flit_cyc[n0+2] - flit_cyc[n0+1], 4);
    end
    check("gap_credits_end", dut.u_credit.count, 4);

    check("all_flits_seen", exp_rd, exp_q.size());
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
